// File: rtl/dcache_responder.sv
// Stand-in data cache slave for the EXM-stage request/response bus.
// Ports: clk, reset (sync, active-high), dcache_wdata_bus (106b request), dcache_rdata_bus (34b response).
module dcache_responder #(
   parameter int MEM_WORDS = 4096,
   parameter int REQ_STALL = 0,
   parameter int RESP_LAT  = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [105:0] dcache_wdata_bus,
   output logic [33:0]  dcache_rdata_bus
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int SW = (REQ_STALL > 0) ? $clog2(REQ_STALL + 1) : 1;
   localparam int LW = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

   localparam logic [SW-1:0] STALL_MAX = SW'(REQ_STALL);
   localparam logic [SW-1:0] STALL_ONE = SW'(1);
   localparam logic [LW-1:0] LAT_INIT  = LW'(RESP_LAT - 1);
   localparam logic [LW-1:0] LAT_ONE   = LW'(1);
   localparam bit            LAT_SKIP  = (RESP_LAT == 1);

   if (RESP_LAT < 1) begin : g_bad_lat
      $error("dcache_responder: RESP_LAT must be 1 or more");
   end
   if ((1 << AW) != MEM_WORDS) begin : g_bad_depth
      $error("dcache_responder: MEM_WORDS must be a power of two");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RWAIT = 2'd1,
      RESP  = 2'd2
   } state_t;

   logic        valid;
   logic        op;
   logic [31:0] addr;
   logic        uncached;
   logic [3:0]  awstrb;
   logic [31:0] wdata;
   logic        cacop_en;
   logic [1:0]  cacop_code;
   logic [31:0] cacop_addr;

   assign {valid, op, addr, uncached, awstrb, wdata,
           cacop_en, cacop_code, cacop_addr} = dcache_wdata_bus;

   logic unused_bits;
   assign unused_bits = ^{addr, uncached, cacop_en,
                          cacop_code, cacop_addr};

   logic [AW-1:0] idx;
   assign idx = addr[2 +: AW];

   logic [31:0] mem [MEM_WORDS];

   state_t        state_q, state_d;
   logic [SW-1:0] stall_q, stall_d;
   logic [LW-1:0] lat_q, lat_d;
   logic [31:0]   cap_q;
   logic          ready;
   logic          rvalid;
   logic          rd_acc;
   logic          wr_acc;

   always_comb begin
      state_d = state_q;
      stall_d = stall_q;
      lat_d   = lat_q;
      ready   = 1'b0;
      rvalid  = 1'b0;
      rd_acc  = 1'b0;
      wr_acc  = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready = valid && (stall_q == STALL_MAX);
            if (!valid) begin
               stall_d = '0;
            end else if (ready) begin
               stall_d = '0;
               if (op) begin
                  wr_acc = 1'b1;
               end else begin
                  rd_acc  = 1'b1;
                  lat_d   = LAT_INIT;
                  state_d = LAT_SKIP ? RESP : RWAIT;
               end
            end else if (stall_q != STALL_MAX) begin
               stall_d = stall_q + STALL_ONE;
            end
         end
         // lat_q counts down to 1 here; the RESP cycle is the 0 slot.
         RWAIT: begin
            lat_d = lat_q - LAT_ONE;
            if (lat_q <= LAT_ONE) begin
               state_d = RESP;
            end
         end
         RESP: begin
            rvalid  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         stall_q <= '0;
         lat_q   <= '0;
         cap_q   <= '0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
         lat_q   <= lat_d;
         if (rd_acc) begin
            cap_q <= mem[idx];
         end
      end
   end

   // Contents survive reset; only the write itself is suppressed.
   always_ff @(posedge clk) begin
      if (!reset && wr_acc) begin
         for (int b = 0; b < 4; b++) begin
            if (awstrb[b]) begin
               mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign dcache_rdata_bus = {ready, rvalid,
                              rvalid ? cap_q : 32'h0};

endmodule

// File: tb/tb_dcache_responder.sv
// Directed and scoreboard bench for dcache_responder.
// Two instances: A (REQ_STALL=0, RESP_LAT=1), B (REQ_STALL=2, RESP_LAT=3).
module tb_dcache_responder;

   logic         clk;
   logic         reset;
   logic [105:0] bus_a, bus_b;
   logic [33:0]  rd_a, rd_b;

   int n_chk  = 0;
   int n_pass = 0;
   int viol   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   dcache_responder #(
      .MEM_WORDS(4096), .REQ_STALL(0), .RESP_LAT(1)
   ) u_a (
      .clk(clk), .reset(reset),
      .dcache_wdata_bus(bus_a), .dcache_rdata_bus(rd_a)
   );

   dcache_responder #(
      .MEM_WORDS(4096), .REQ_STALL(2), .RESP_LAT(3)
   ) u_b (
      .clk(clk), .reset(reset),
      .dcache_wdata_bus(bus_b), .dcache_rdata_bus(rd_b)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   function automatic logic [105:0] mk(
      input bit v, input bit op, input logic [31:0] a,
      input logic [3:0] s, input logic [31:0] d);
      return {v, op, a, 1'b1, s, d, 1'b1, 2'b10, 32'h5A5A_0F0F};
   endfunction

   task automatic drive(input bit sel, input logic [105:0] b);
      if (sel) bus_b = b;
      else     bus_a = b;
   endtask

   function automatic logic rdy(input bit sel);
      return sel ? rd_b[33] : rd_a[33];
   endfunction

   function automatic logic rv(input bit sel);
      return sel ? rd_b[32] : rd_a[32];
   endfunction

   function automatic logic [31:0] dat(input bit sel);
      return sel ? rd_b[31:0] : rd_a[31:0];
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic wait_rv(input bit sel, output logic [31:0] d);
      bit got = 0;
      d = '0;
      for (int i = 0; i < 32; i++) begin
         settle();
         if (rv(sel)) begin
            d = dat(sel);
            got = 1;
            break;
         end
         cyc();
      end
      if (!got) chk("timeout_rvalid", 32'd0, 32'd1);
      cyc();
   endtask

   task automatic xact(input bit sel, input bit op,
                       input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] wd,
                       output logic [31:0] d);
      bit got = 0;
      d = '0;
      drive(sel, mk(1'b1, op, a, s, wd));
      for (int i = 0; i < 32; i++) begin
         settle();
         if (rdy(sel)) begin
            got = 1;
            break;
         end
         cyc();
      end
      if (!got) begin
         chk("timeout_ready", 32'd0, 32'd1);
         drive(sel, '0);
         cyc();
      end else begin
         cyc();
         drive(sel, '0);
         if (!op) wait_rv(sel, d);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (rd_a[33] && rd_a[32]) viol++;
         if (rd_b[33] && rd_b[32]) viol++;
         if (rd_a[33] && !bus_a[105]) viol++;
         if (rd_b[33] && !bus_b[105]) viol++;
         if (!rd_a[32] && rd_a[31:0] != 0) viol++;
         if (!rd_b[32] && rd_b[31:0] != 0) viol++;
      end
   end

   logic [31:0] mdl   [2][4096];
   bit          wr_ok [2][4096];

   initial begin : main
      logic [31:0] d;
      logic [8:0]  rdy_v, rv_v;
      logic [31:0] held_d;
      int          seen;

      reset = 1'b1;
      bus_a = '0;
      bus_b = '0;
      cyc();
      cyc();
      settle();
      chk("rst_a_ready",  {31'd0, rd_a[33]}, 32'd0);
      chk("rst_a_rvalid", {31'd0, rd_a[32]}, 32'd0);
      chk("rst_a_rdata",  rd_a[31:0], 32'd0);
      chk("rst_b_bus",    {30'd0, rd_b[33:32]}, 32'd0);
      chk("rst_b_rdata",  rd_b[31:0], 32'd0);
      cyc();
      reset = 1'b0;
      cyc();

      drive(0, mk(1, 1, 32'h100, 4'hF, 32'hDEADBEEF));
      settle();
      chk("wr_ready_same", {31'd0, rdy(0)}, 32'd1);
      cyc();
      drive(0, '0);
      settle();
      chk("wr_no_rvalid", {31'd0, rv(0)}, 32'd0);
      cyc();

      drive(0, mk(1, 0, 32'h100, 4'h0, 32'h0));
      settle();
      chk("rd_ready_same", {31'd0, rdy(0)}, 32'd1);
      chk("rd_rv_early", {31'd0, rv(0)}, 32'd0);
      cyc();
      drive(0, '0);
      settle();
      chk("rd_rvalid", {31'd0, rv(0)}, 32'd1);
      chk("rd_data", dat(0), 32'hDEADBEEF);
      chk("rd_rv_noready", {31'd0, rdy(0)}, 32'd0);
      cyc();
      settle();
      chk("rd_rv_once", {31'd0, rv(0)}, 32'd0);
      chk("rd_data_zero", dat(0), 32'd0);
      cyc();

      xact(0, 1, 32'h200, 4'hF, 32'h11223344, d);
      xact(0, 1, 32'h200, 4'b0100, 32'h00AA0000, d);
      xact(0, 0, 32'h200, 4'hF, 32'hFFFFFFFF, d);
      chk("strb_byte2", d, 32'h11AA3344);
      xact(0, 1, 32'h200, 4'h0, 32'hFFFFFFFF, d);
      xact(0, 0, 32'h200, 4'h0, 32'h0, d);
      chk("strb_zero", d, 32'h11AA3344);
      xact(0, 1, 32'h200, 4'b1001, 32'h77FFFF55, d);
      xact(0, 0, 32'h200, 4'h0, 32'h0, d);
      chk("strb_1001", d, 32'h77AA3355);

      xact(0, 1, 32'h0000_4004, 4'hF, 32'hCAFEF00D, d);
      xact(0, 0, 32'h0000_0004, 4'h0, 32'h0, d);
      chk("wrap_4096", d, 32'hCAFEF00D);

      xact(0, 1, 32'h500, 4'hF, 32'hAAAAAAAA, d);
      drive(0, mk(1, 1, 32'h500, 4'b0011, 32'h0000BEEF));
      settle();
      chk("b2b_wr_ready", {31'd0, rdy(0)}, 32'd1);
      cyc();
      drive(0, mk(1, 0, 32'h500, 4'h0, 32'h0));
      settle();
      chk("b2b_rd_ready", {31'd0, rdy(0)}, 32'd1);
      cyc();
      drive(0, '0);
      settle();
      chk("b2b_rvalid", {31'd0, rv(0)}, 32'd1);
      chk("b2b_data", dat(0), 32'hAAAABEEF);
      cyc();

      xact(0, 1, 32'h300, 4'hF, 32'h13579BDF, d);
      drive(0, mk(1, 1, 32'h300, 4'hF, 32'h0));
      reset = 1'b1;
      cyc();
      drive(0, '0);
      cyc();
      reset = 1'b0;
      cyc();
      xact(0, 0, 32'h300, 4'h0, 32'h0, d);
      chk("rst_blocks_wr", d, 32'h13579BDF);

      xact(1, 1, 32'h100, 4'hF, 32'h0BADF00D, d);
      drive(1, mk(1, 0, 32'h100, 4'h0, 32'h0));
      settle();
      chk("stall_t0", {31'd0, rdy(1)}, 32'd0);
      cyc();
      settle();
      chk("stall_t1", {31'd0, rdy(1)}, 32'd0);
      cyc();
      settle();
      chk("stall_t2", {31'd0, rdy(1)}, 32'd1);
      cyc();
      drive(1, '0);
      settle();
      chk("lat_t3", {31'd0, rv(1)}, 32'd0);
      cyc();
      settle();
      chk("lat_t4", {31'd0, rv(1)}, 32'd0);
      cyc();
      settle();
      chk("lat_t5", {31'd0, rv(1)}, 32'd1);
      chk("lat_data", dat(1), 32'h0BADF00D);
      cyc();
      settle();
      chk("lat_t6", {31'd0, rv(1)}, 32'd0);
      cyc();

      drive(1, mk(1, 0, 32'h100, 4'h0, 32'h0));
      settle();
      chk("drop_t0", {31'd0, rdy(1)}, 32'd0);
      cyc();
      drive(1, '0);
      settle();
      chk("drop_t1", {31'd0, rdy(1)}, 32'd0);
      cyc();
      cyc();
      drive(1, mk(1, 0, 32'h100, 4'h0, 32'h0));
      settle();
      chk("drop_t3", {31'd0, rdy(1)}, 32'd0);
      cyc();
      settle();
      chk("drop_t4", {31'd0, rdy(1)}, 32'd0);
      cyc();
      settle();
      chk("drop_t5", {31'd0, rdy(1)}, 32'd1);
      cyc();
      drive(1, '0);
      wait_rv(1, d);
      chk("drop_data", d, 32'h0BADF00D);

      drive(1, mk(1, 0, 32'h100, 4'h0, 32'h0));
      rdy_v  = '0;
      rv_v   = '0;
      held_d = '0;
      for (int i = 0; i < 9; i++) begin
         settle();
         rdy_v[i] = rdy(1);
         rv_v[i]  = rv(1);
         if (rv(1)) held_d = dat(1);
         cyc();
      end
      drive(1, '0);
      chk("held_ready", {23'd0, rdy_v}, 32'h104);
      chk("held_rvalid", {23'd0, rv_v}, 32'h020);
      chk("held_data", held_d, 32'h0BADF00D);
      wait_rv(1, d);
      chk("held_2nd", d, 32'h0BADF00D);

      drive(1, mk(1, 0, 32'h100, 4'h0, 32'h0));
      seen = 0;
      for (int i = 0; i < 32 && !rdy(1); i++) begin
         settle();
         if (!rdy(1)) cyc();
      end
      cyc();
      drive(1, '0);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      settle();
      chk("rstmid_ready", {31'd0, rdy(1)}, 32'd0);
      chk("rstmid_rvalid", {31'd0, rv(1)}, 32'd0);
      chk("rstmid_rdata", dat(1), 32'd0);
      for (int i = 0; i < 8; i++) begin
         cyc();
         settle();
         if (rv(1)) seen++;
      end
      chk("rstmid_no_rv", seen, 32'd0);
      cyc();

      for (int n = 0; n < 200; n++) begin
         bit          sel, op;
         int          wi;
         logic [3:0]  s;
         logic [31:0] wd, a;
         sel = 1'($urandom_range(0, 1));
         wi  = $urandom_range(0, 31);
         op  = 1'($urandom_range(0, 1));
         s   = 4'($urandom_range(0, 15));
         wd  = $urandom();
         if (!wr_ok[sel][wi]) begin
            op = 1'b1;
            s  = 4'hF;
         end
         a = ($urandom() & 32'hFFFF_C000)
           | (32'(wi) << 2)
           | 32'($urandom_range(0, 3));
         xact(sel, op, a, s, wd, d);
         if (op) begin
            for (int b = 0; b < 4; b++)
               if (s[b]) mdl[sel][wi][8*b +: 8] = wd[8*b +: 8];
            wr_ok[sel][wi] = 1'b1;
         end else begin
            chk($sformatf("stress_%0d", n), d, mdl[sel][wi]);
         end
      end

      chk("invariants", viol, 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
